uart_rx_core: RTL and testbench

Serial receive half of the UART, the downstream counterpart of the transmit controller/shifter. It consumes the asynchronous line `Rx` (8N1 framing, LSB first, idle high, the same format the transmitter produces) and runs its own bit-period counter. For each well-formed frame it presents one parallel byte with a single-cycle `Valid` strobe. Malformed frames are flagged with error strobes, and no data is delivered for them.

---
 rtl/uart_rx_core.sv | 141 ++++++++++++++
 tb/tb_uart_rx_core.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receive core: 2-flop synchronized Rx, mid-bit sampling, 8N1 framing by default.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra PARITY state and a ParityErr strobe.
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] Data,
   output logic                 Valid,
   output logic                 FrameErr,
   output logic                 Busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 ParityErr
`endif
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif

   logic                 rx_m;
   logic                 rx_s;
   logic                 rx_d;
   logic [2:0]           state;
   logic [2:0]           state_nx;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 at_half;
   logic                 at_full;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= Rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign at_half = (cnt == HALF_M1);
   assign at_full = (cnt == FULL_M1);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (rx_d && !rx_s) state_nx = S_START;
         S_START: if (at_half) state_nx = rx_s ? S_IDLE : S_DATA;
         S_DATA: begin
            if (at_full && idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
               state_nx = S_PARITY;
`else
               state_nx = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (at_full) state_nx = S_STOP;
`endif
         S_STOP:  if (at_full) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx      <= '0;
         shreg    <= '0;
         Data     <= '0;
         Valid    <= 1'b0;
         FrameErr <= 1'b0;
         Busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit   <= 1'b0;
         ParityErr <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         Busy     <= (state_nx != S_IDLE);
         Valid    <= 1'b0;
         FrameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
         ParityErr <= 1'b0;
`endif
         // any state change clears the bit timer; DATA also restarts it after each sample
         if (state_nx != state) begin
            cnt <= '0;
            idx <= '0;
         end else if (state == S_DATA && at_full) begin
            cnt <= '0;
            idx <= idx + 1'b1;
         end else if (state != S_IDLE) begin
            cnt <= cnt + 1'b1;
         end

         if (state == S_DATA && at_full)
            shreg[idx] <= rx_s;

`ifdef UART_RX_PARITY_EN
         if (state == S_PARITY && at_full)
            par_bit <= rx_s;
`endif

         if (state == S_STOP && at_full) begin
            if (rx_s) begin
               Data  <= shreg;
               Valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
               ParityErr <= ^{shreg, par_bit};
`endif
            end else begin
               FrameErr <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames, line-history model checked every cycle.
module tb_uart_rx_core;

   localparam int C = 16;
   localparam int D = 8;
   localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int STROBE = 2 + H + (D + 1 + P) * C;
   localparam int HMAX   = 10000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       Rx = 1'b1;
   logic [7:0] Data;
   logic       Valid;
   logic       FrameErr;
   logic       Busy;
`ifdef UART_RX_PARITY_EN
   logic       ParityErr;
`endif

   uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .Rx       (Rx),
      .Data     (Data),
      .Valid    (Valid),
      .FrameErr (FrameErr),
`ifdef UART_RX_PARITY_EN
      .ParityErr(ParityErr),
`endif
      .Busy     (Busy)
   );

   always #5 clk = ~clk;

   int  n = 0;
   int  checks = 0;
   int  fails = 0;
   bit  hist [0:HMAX-1];

   bit         m_busy = 1'b0;
   int         m_e = 0;
   logic [7:0] m_data = '0;
   bit         e_valid, e_ferr, e_perr;
   bit         prev_busy = 1'b0;
   int         bfall = -1;

   int         lg_cyc[$];
   logic [7:0] lg_dat[$];
   bit         lg_fe[$];
   bit         lg_pe[$];

   function automatic bit line(int c);
      return (c >= 0 && c < HMAX) ? hist[c] : 1'b1;
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, n, act, exp);
      end
   endtask

   // Model: line value seen at each edge; a frame found at edge E is sampled at E+H+k*C.
   initial begin
      logic [7:0] b;
      bit pb, sb;
      forever begin
         @(posedge clk);
         n++;
         if (n < HMAX) hist[n] = reset_n ? Rx : 1'b1;
         e_valid = 0; e_ferr = 0; e_perr = 0;
         if (!reset_n) begin
            m_busy = 0;
            m_data = '0;
         end else if (!m_busy) begin
            if (line(n-3) && !line(n-2)) begin
               m_busy = 1;
               m_e = n - 2;
            end
         end else if (n == m_e + 2 + H) begin
            if (line(m_e + H)) m_busy = 0;
         end else if (n == m_e + STROBE) begin
            for (int k = 0; k < D; k++) b[k] = line(m_e + H + (k + 1) * C);
            pb = line(m_e + H + (D + 1) * C);
            sb = line(m_e + H + (D + 1 + P) * C);
            m_busy = 0;
            if (sb) begin
               e_valid = 1;
               m_data = b;
               e_perr = (P == 1) ? (^b ^ pb) : 1'b0;
            end else begin
               e_ferr = 1;
            end
         end
         #1;
         check("valid", Valid, e_valid);
         check("frameerr", FrameErr, e_ferr);
         check("busy", Busy, m_busy);
         check("data", Data, m_data);
`ifdef UART_RX_PARITY_EN
         check("parityerr", ParityErr, e_perr);
`endif
         if (prev_busy && !Busy) bfall = n;
         prev_busy = Busy;
         if (Valid || FrameErr) begin
            lg_cyc.push_back(n);
            lg_dat.push_back(Data);
            lg_fe.push_back(FrameErr);
`ifdef UART_RX_PARITY_EN
            lg_pe.push_back(ParityErr);
`else
            lg_pe.push_back(1'b0);
`endif
         end
      end
   end

   task automatic clear_log();
      lg_cyc.delete(); lg_dat.delete(); lg_fe.delete(); lg_pe.delete();
   endtask

   task automatic idle(int k);
      Rx = 1'b1;
      repeat (k) @(negedge clk);
   endtask

   task automatic send_bit(bit v);
      Rx = v;
      repeat (C) @(negedge clk);
   endtask

   task automatic send_frame(logic [7:0] d, bit par, bit stop, output int e);
      e = n + 1;
      send_bit(1'b0);
      for (int k = 0; k < D; k++) send_bit(d[k]);
      if (P == 1) send_bit(par);
      send_bit(stop);
   endtask

   initial begin
      int e, e0, e1, e2;
      reset_n = 1'b0;
      Rx = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", Data, 8'h00);
      check("rst_busy", Busy, 1'b0);
      check("rst_valid", Valid, 1'b0);
      reset_n = 1'b1;
      idle(10);

      // good frame
      clear_log();
      send_frame(8'hA5, 1'b0, 1'b1, e);
      idle(10);
      check("t1_count", lg_cyc.size(), 1);
      if (lg_cyc.size() > 0) begin
         check("t1_cycle", lg_cyc[0] - e, (P == 1) ? 170 : 154);
         check("t1_data", lg_dat[0], 8'hA5);
         check("t1_ferr", lg_fe[0], 1'b0);
      end

      // 3-cycle glitch
      clear_log();
      e = n + 1;
      Rx = 1'b0;
      repeat (3) @(negedge clk);
      idle(30);
      check("t2_none", lg_cyc.size(), 0);
      check("t2_busy_fall", bfall - e, 10);
      check("t2_data", Data, 8'hA5);

      // bad stop bit, line stays low
      clear_log();
      send_frame(8'h3C, 1'b0, 1'b0, e);
      repeat (100) @(negedge clk);
      check("t3_count", lg_cyc.size(), 1);
      if (lg_cyc.size() > 0) begin
         check("t3_ferr", lg_fe[0], 1'b1);
         check("t3_cycle", lg_cyc[0] - e, (P == 1) ? 170 : 154);
      end
      check("t3_data", Data, 8'hA5);
      check("t3_idle", Busy, 1'b0);
      idle(20);
      check("t3_no_restart", lg_cyc.size(), 1);

      // back-to-back frames
      clear_log();
      send_frame(8'h00, 1'b0, 1'b1, e0);
      send_frame(8'hFF, 1'b0, 1'b1, e1);
      send_frame(8'h81, 1'b0, 1'b1, e2);
      idle(20);
      check("t4_count", lg_cyc.size(), 3);
      if (lg_cyc.size() == 3) begin
         check("t4_gap1", lg_cyc[1] - lg_cyc[0], (P == 1) ? 176 : 160);
         check("t4_gap2", lg_cyc[2] - lg_cyc[1], (P == 1) ? 176 : 160);
         check("t4_d0", lg_dat[0], 8'h00);
         check("t4_d1", lg_dat[1], 8'hFF);
         check("t4_d2", lg_dat[2], 8'h81);
      end

      // reset during data bit 4 of 0x55 with the line low
      clear_log();
      send_bit(1'b0);
      for (int k = 0; k < 4; k++) send_bit(k[0] ? 1'b0 : 1'b1);
      Rx = 1'b0;
      repeat (8) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("t5_rst_data", Data, 8'h00);
      check("t5_rst_busy", Busy, 1'b0);
      check("t5_rst_valid", Valid, 1'b0);
      check("t5_rst_ferr", FrameErr, 1'b0);
      repeat (4) @(negedge clk);
      Rx = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      idle(200);
      check("t5_none", lg_cyc.size(), 0);
      send_frame(8'h12, 1'b0, 1'b1, e);
      idle(10);
      check("t5_count", lg_cyc.size(), 1);
      if (lg_cyc.size() > 0) begin
         check("t5_data", lg_dat[0], 8'h12);
         check("t5_cycle", lg_cyc[0] - e, (P == 1) ? 170 : 154);
      end

`ifdef UART_RX_PARITY_EN
      // even parity: 0x07 has three ones
      clear_log();
      send_frame(8'h07, 1'b1, 1'b1, e);
      idle(10);
      send_frame(8'h07, 1'b0, 1'b1, e1);
      idle(10);
      check("t6_count", lg_cyc.size(), 2);
      if (lg_cyc.size() == 2) begin
         check("t6_d0", lg_dat[0], 8'h07);
         check("t6_pe0", lg_pe[0], 1'b0);
         check("t6_d1", lg_dat[1], 8'h07);
         check("t6_pe1", lg_pe[1], 1'b1);
         check("t6_cycle", lg_cyc[1] - e1, 170);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
